// File: rtl/ifm_row_streamer_pkg.sv
// Shared definitions for the IFM row streamer and the PE IFM input side.
package ifm_row_streamer_pkg;

  // Streamer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } ifm_state_t;

  // Row tags carried next to each IFM element
  typedef struct packed {
    logic sor;
    logic eor;
  } ifm_tag_t;

  localparam int unsigned TAG_WIDTH = 2;

  // Start-of-row tag sits directly above end-of-row, both above the element
  function automatic int unsigned sor_pos(input int unsigned data_width);
    return data_width + 1;
  endfunction

  function automatic int unsigned eor_pos(input int unsigned data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/ifm_skid_fifo.sv
// Two-entry skid buffer with a registered head; head reads 0 when empty.
module ifm_skid_fifo #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: no pop when empty, no push when full unless popping too
  always_comb begin
    do_pop  = pop & (count != 2'd0);
    do_push = push & ((count != 2'd2) | do_pop);
  end

  // Storage update; simultaneous push/pop keeps occupancy and shifts the tail up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head_q <= din;
          else               tail_q <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_q <= tail_q;
            tail_q <= '0;
          end else begin
            head_q <= '0;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = head_q;

endmodule

// File: rtl/ifm_row_streamer.sv
// Streams IFM words row by row from a sync-read buffer into the PE IFM port.
module ifm_row_streamer
  import ifm_row_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    row_len,
  input  logic [LEN_WIDTH-1:0]    num_rows,
  output logic                    mem_rd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    ready_ifm,
  output logic                    w_en_ifm,
  output logic [DATA_WIDTH+1:0]   data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam int unsigned SOR_POS    = sor_pos(DATA_WIDTH);
  localparam int unsigned EOR_POS    = eor_pos(DATA_WIDTH);

  ifm_state_t state;
  ifm_state_t state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  col_q;
  logic [LEN_WIDTH-1:0]  row_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rows_q;
  logic                  inflight_q;
  ifm_tag_t              tag_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  done_next;
  logic                  busy_next;
  logic                  zero_len;
  logic                  last_col;
  logic                  last_row;
  logic [1:0]            occ;
  logic [1:0]            occ_after;
  logic                  credit_ok;
  logic                  drained;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_din;
  logic [WORD_WIDTH-1:0] fifo_head;

  // Skid buffer between the memory return path and the PE write port
  ifm_skid_fifo #(
    .WIDTH (WORD_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (w_en_ifm),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Returned element joined with the tags that travelled with its read
  always_comb begin
    fifo_din                   = '0;
    fifo_din[DATA_WIDTH-1:0]   = mem_data;
    fifo_din[SOR_POS]          = tag_q.sor;
    fifo_din[EOR_POS]          = tag_q.eor;
  end

  // Occupancy bookkeeping; a pop this cycle frees a slot for a read issued now
  always_comb begin
    zero_len  = (row_len == '0) || (num_rows == '0);
    last_col  = (col_q == len_q - LEN_WIDTH'(1));
    last_row  = (row_q == rows_q - LEN_WIDTH'(1));
    occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    occ_after = occ - 2'(w_en_ifm);
    credit_ok = (occ_after + 2'(inflight_q)) < 2'd2;
    drained   = !inflight_q && (occ_after == 2'd0);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = zero_len ? ST_FLUSH : ST_STREAM;
      end
      ST_STREAM: begin
        if (mem_rd && last_col && last_row) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (drained) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: read issue, completion and busy for the next cycle
  always_comb begin
    mem_rd    = 1'b0;
    done_next = 1'b0;
    busy_next = (state_next != ST_IDLE);
    case (state)
      ST_STREAM: mem_rd    = credit_ok;
      ST_FLUSH:  done_next = drained;
      default: ;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= done_next;
      busy_q <= busy_next;
    end
  end

  // Transfer parameters, address and position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      len_q  <= '0;
      rows_q <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        addr_q <= base_addr;
        len_q  <= row_len;
        rows_q <= num_rows;
        col_q  <= '0;
        row_q  <= '0;
      end
    end else if (mem_rd) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + LEN_WIDTH'(1);
      end else begin
        col_q <= col_q + LEN_WIDTH'(1);
      end
    end
  end

  // In-flight flag and tags for the read whose data returns next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= mem_rd;
      if (mem_rd) begin
        tag_q.sor <= (col_q == '0);
        tag_q.eor <= last_col;
      end
    end
  end

  assign mem_addr = addr_q;
  assign w_en_ifm = !fifo_empty && ready_ifm;
  assign data_out = fifo_head;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ifm_row_streamer.sv
// Directed self-checking bench for ifm_row_streamer.
module tb_ifm_row_streamer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] row_len = '0;
  logic [LW-1:0] num_rows = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic          ready_ifm = 1'b0;
  logic          w_en_ifm;
  logic [DW+1:0] data_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ifm_row_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_len   (row_len),
    .num_rows  (num_rows),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .ready_ifm (ready_ifm),
    .w_en_ifm  (w_en_ifm),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Cycle counter and synchronous-read buffer model: memory[i] = i
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= mem_addr[DW-1:0];
  end

  // Observation log, cleared on request from the stimulus process
  logic          mon_clr = 1'b0;
  logic [DW+1:0] wq[$];
  int            wcyc[$];
  logic [AW-1:0] aq[$];
  int            rcyc[$];
  int            n_rd = 0;
  int            n_wr = 0;
  int            max_out = 0;
  bit            bad_wr = 1'b0;
  bit            done_seen = 1'b0;
  int            done_cyc = 0;
  int            done_cnt = 0;
  logic          busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      wq.delete(); wcyc.delete(); aq.delete(); rcyc.delete();
      n_rd = 0; n_wr = 0; max_out = 0; bad_wr = 1'b0;
      done_seen = 1'b0; done_cyc = 0; done_cnt = 0; busy_at_done = 1'b0;
    end else begin
      if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;
      if (w_en_ifm) begin
        wq.push_back(data_out);
        wcyc.push_back(cyc);
        n_wr++;
        if (!ready_ifm) bad_wr = 1'b1;
      end
      if (mem_rd) begin
        aq.push_back(mem_addr);
        rcyc.push_back(cyc);
        n_rd++;
      end
      if (done) begin
        done_seen    = 1'b1;
        done_cyc     = cyc;
        done_cnt++;
        busy_at_done = busy;
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1; mon_clr = 1'b1;
    @(posedge clk); #1; mon_clr = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l,
                          input logic [LW-1:0] r, output int t);
    @(posedge clk); #1;
    base_addr = b; row_len = l; num_rows = r; start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      if (done_seen) break;
      @(posedge clk); #1;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s_timeout: done not seen, required within 300 cycles", name);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_rd, w_en_ifm, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {mem_rd, w_en_ifm, busy, done});
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h required 000", mem_addr);
    end
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 000", data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_words(input string name, input logic [DW+1:0] exp[$]);
    logic [DW+1:0] got;
    checks++;
    if (wq.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d writes required %0d", name, wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got %h required %h", name, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_basic();
    int t;
    logic [DW+1:0] exp[$];
    exp = '{10'h210, 10'h011, 10'h112, 10'h213, 10'h014, 10'h115};
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h010, 6'd3, 6'd2, t);
    wait_done("basic");
    check_words("basic", exp);
    checks++;
    if (rcyc.size() == 0 || rcyc[0] != t + 1) begin
      errors++;
      $display("FAIL basic_first_rd: got cycle %0d required %0d", (rcyc.size() > 0) ? rcyc[0] - t : -1, 1);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= wcyc.size() || wcyc[i] != t + 3 + i) begin
        errors++;
        $display("FAIL basic_wr_cycle%0d: got %0d required %0d", i, (i < wcyc.size()) ? wcyc[i] - t : -1, 3 + i);
      end
    end
    checks++;
    if (wcyc.size() != 6 || done_cyc != wcyc[5] + 1) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc - t, 9);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done);
    end
  endtask

  task automatic test_ready_toggle();
    int t;
    logic [3:0] pat;
    logic [DW+1:0] exp[$];
    exp = '{10'h210, 10'h011, 10'h112, 10'h213, 10'h014, 10'h115};
    pat = 4'b1001;
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h010, 6'd3, 6'd2, t);
    for (int k = 0; k < 300; k++) begin
      ready_ifm = pat[k % 4];
      if (done_seen) break;
      @(posedge clk); #1;
    end
    ready_ifm = 1'b1;
    wait_done("toggle");
    check_words("toggle", exp);
    checks++;
    if (bad_wr) begin
      errors++;
      $display("FAIL toggle_wr_while_not_ready: got 1 required 0");
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL toggle_outstanding: got %0d required <=2", max_out);
    end
  endtask

  task automatic test_single_col();
    int t;
    logic [DW+1:0] exp[$];
    exp = '{10'h320, 10'h321, 10'h322};
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h020, 6'd1, 6'd3, t);
    wait_done("single_col");
    check_words("single_col", exp);
  endtask

  task automatic test_wrap();
    int t;
    logic [DW+1:0] exp[$];
    logic [AW-1:0] exp_a[4];
    exp = '{10'h2FE, 10'h0FF, 10'h000, 10'h101};
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h3FE, 6'd4, 6'd1, t);
    wait_done("wrap");
    check_words("wrap", exp);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= aq.size() || aq[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h required %h", i, (i < aq.size()) ? aq[i] : 'x, exp_a[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    int t;
    int t2;
    logic [DW+1:0] exp[$];
    exp = '{10'h240, 10'h141, 10'h242, 10'h143};
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h030, 6'd0, 6'd2, t);
    wait_done("zero_len");
    checks++;
    if (done_cyc != t + 2) begin
      errors++;
      $display("FAIL zero_len_done_cycle: got %0d required %0d", done_cyc - t, 2);
    end
    checks++;
    if (n_rd != 0 || n_wr != 0) begin
      errors++;
      $display("FAIL zero_len_traffic: got %0d reads %0d writes required 0 0", n_rd, n_wr);
    end
    // Second start mid-transfer must be ignored
    clear_mon();
    do_start(10'h040, 6'd2, 6'd2, t);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got %b required 1", busy);
    end
    do_start(10'h100, 6'd5, 6'd5, t2);
    wait_done("ignore");
    check_words("ignore", exp);
    checks++;
    if (n_rd != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_reads: got %0d reads %0d done required 4 1", n_rd, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [DW+1:0] exp[$];
    exp = '{10'h210, 10'h011, 10'h112, 10'h213, 10'h014, 10'h115};
    clear_mon();
    ready_ifm = 1'b1;
    do_start(10'h010, 6'd3, 6'd2, t);
    for (int i = 0; i < 50; i++) begin
      if (wq.size() >= 2) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, w_en_ifm, busy, done, mem_addr, data_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rd=%b wen=%b busy=%b done=%b addr=%h data=%h required all 0",
               mem_rd, w_en_ifm, busy, done, mem_addr, data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_seen || n_wr != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got done=%b writes=%0d required 0 0", done_seen, n_wr);
    end
    clear_mon();
    do_start(10'h010, 6'd3, 6'd2, t);
    wait_done("reset_rerun");
    check_words("reset_rerun", exp);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_single_col();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
